// File: rtl/camera_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : camera_config_sequencer
// Description : Walks a synchronous config ROM of {reg, val} entries and
//               issues each one as a write request to an SCCB master.
//               16'hFFFF ends the table, 16'hFFF0 inserts a settle delay and
//               a write of reg 0x12 = 0x80 (sensor soft reset) is followed by
//               the same settle delay. NACKed writes are re-issued up to
//               MAX_RETRY times before the sequence stops with an error.
// Ports       : clock, reset (async, active low), start pulse
//               rom_addr / rom_data       : config ROM (1-cycle read latency)
//               sccb_valid/ready/reg/val  : write request handshake
//               sccb_done / sccb_nack     : write completion status
//               busy, done, error, err_index : sequence status
// Revision    : 1.0 - initial release
// ============================================================================
module camera_config_sequencer #(
    parameter int ROM_AW       = 8,
    parameter int DELAY_CYCLES = 1_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic [ROM_AW-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              sccb_valid,
    input  logic              sccb_ready,
    output logic [7:0]        sccb_reg,
    output logic [7:0]        sccb_val,
    input  logic              sccb_done,
    input  logic              sccb_nack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ROM_AW-1:0] err_index
);

    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int c_DLY_W   = $clog2(DELAY_CYCLES + 1);

    localparam logic [15:0]          c_END_MARK   = 16'hFFFF;
    localparam logic [15:0]          c_DELAY_MARK = 16'hFFF0;
    localparam logic [15:0]          c_SOFT_RESET = 16'h1280;
    localparam logic [ROM_AW-1:0]    c_LAST_ADDR  = {ROM_AW{1'b1}};
    localparam logic [c_DLY_W-1:0]   c_DLY_LOAD   = c_DLY_W'(DELAY_CYCLES - 1);
    localparam logic [c_RETRY_W-1:0] c_RETRY_MAX  = c_RETRY_W'(MAX_RETRY);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        FETCH     = 3'd1,
        LATCH     = 3'd2,
        ISSUE     = 3'd3,
        WAIT_DONE = 3'd4,
        DELAY     = 3'd5,
        DONE      = 3'd6,
        ERROR     = 3'd7
    } state_t;

    state_t               r_state,     w_state_nxt;
    logic [ROM_AW-1:0]    r_addr,      w_addr_nxt;
    logic [15:0]          r_entry,     w_entry_nxt;
    logic [c_RETRY_W-1:0] r_retry,     w_retry_nxt;
    logic [c_DLY_W-1:0]   r_dly_cnt,   w_dly_nxt;
    logic [ROM_AW-1:0]    r_err_index, w_err_nxt;

    // Where "advance" leads: the last ROM slot ends the sequence instead of
    // wrapping back to address 0.
    state_t               w_adv_state;
    logic [ROM_AW-1:0]    w_adv_addr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_entry     <= '0;
            r_retry     <= '0;
            r_dly_cnt   <= '0;
            r_err_index <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_entry     <= w_entry_nxt;
            r_retry     <= w_retry_nxt;
            r_dly_cnt   <= w_dly_nxt;
            r_err_index <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_entry_nxt = r_entry;
        w_retry_nxt = r_retry;
        w_dly_nxt   = r_dly_cnt;
        w_err_nxt   = r_err_index;

        if (r_addr == c_LAST_ADDR) begin
            w_adv_state = DONE;
            w_adv_addr  = r_addr;
        end else begin
            w_adv_state = FETCH;
            w_adv_addr  = r_addr + 1'b1;
        end

        case (r_state)
            IDLE, DONE, ERROR: begin
                if (start) begin
                    w_state_nxt = FETCH;
                    w_addr_nxt  = '0;
                    w_retry_nxt = '0;
                end
            end
            FETCH: begin
                w_state_nxt = LATCH;
            end
            LATCH: begin
                // rom_data is valid here for the address driven in FETCH;
                // decode straight from it and keep a copy for ISSUE.
                w_entry_nxt = rom_data;
                if (rom_data == c_END_MARK) begin
                    w_state_nxt = DONE;
                end else if (rom_data == c_DELAY_MARK) begin
                    w_state_nxt = DELAY;
                    w_dly_nxt   = c_DLY_LOAD;
                end else begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (sccb_ready) begin
                    w_state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (sccb_done) begin
                    if (sccb_nack) begin
                        if (r_retry >= c_RETRY_MAX) begin
                            w_err_nxt   = r_addr;
                            w_state_nxt = ERROR;
                        end else begin
                            w_retry_nxt = r_retry + 1'b1;
                            w_state_nxt = ISSUE;
                        end
                    end else begin
                        w_retry_nxt = '0;
                        if (r_entry == c_SOFT_RESET) begin
                            w_state_nxt = DELAY;
                            w_dly_nxt   = c_DLY_LOAD;
                        end else begin
                            w_state_nxt = w_adv_state;
                            w_addr_nxt  = w_adv_addr;
                        end
                    end
                end
            end
            DELAY: begin
                // Counter is loaded with DELAY_CYCLES-1 on entry, so leaving
                // on zero gives exactly DELAY_CYCLES clocks in this state.
                if (r_dly_cnt == '0) begin
                    w_state_nxt = w_adv_state;
                    w_addr_nxt  = w_adv_addr;
                end else begin
                    w_dly_nxt = r_dly_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Outputs decode directly from registers so the asynchronous reset
    // clears them without waiting for a clock edge.
    assign rom_addr   = r_addr;
    assign sccb_valid = (r_state == ISSUE);
    assign sccb_reg   = r_entry[15:8];
    assign sccb_val   = r_entry[7:0];
    assign busy       = (r_state == FETCH) || (r_state == LATCH) ||
                        (r_state == ISSUE) || (r_state == WAIT_DONE) ||
                        (r_state == DELAY);
    assign done       = (r_state == DONE);
    assign error      = (r_state == ERROR);
    assign err_index  = r_err_index;

endmodule
`default_nettype wire

// File: tb/tb_camera_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_camera_config_sequencer
// Description : Directed bench for camera_config_sequencer with a small
//               synchronous ROM and a behavioural SCCB master (programmable
//               ready stall and per-entry NACK counts).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_camera_config_sequencer;

    localparam int ROM_AW       = 2;
    localparam int DELAY_CYCLES = 4;
    localparam int MAX_RETRY    = 3;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [ROM_AW-1:0] rom_addr;
    logic [15:0]       rom_data = 16'h0000;
    logic              sccb_valid;
    logic              sccb_ready;
    logic [7:0]        sccb_reg;
    logic [7:0]        sccb_val;
    logic              sccb_done;
    logic              sccb_nack;
    logic              busy;
    logic              done;
    logic              error;
    logic [ROM_AW-1:0] err_index;

    logic [15:0] rom [4];
    int          nack_plan [4];
    int          nack_used [4];
    int          ready_stall = 0;
    int          epoch = 0;
    int          seen_epoch = 0;
    int          base = 0;

    int          cyc = 0;
    int          writes = 0;
    logic [15:0] wlog [64];
    int          wcyc [64];
    logic        nack_this = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;

    camera_config_sequencer #(
        .ROM_AW       (ROM_AW),
        .DELAY_CYCLES (DELAY_CYCLES),
        .MAX_RETRY    (MAX_RETRY)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .sccb_valid (sccb_valid),
        .sccb_ready (sccb_ready),
        .sccb_reg   (sccb_reg),
        .sccb_val   (sccb_val),
        .sccb_done  (sccb_done),
        .sccb_nack  (sccb_nack),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_index  (err_index)
    );

    always #5 clock = ~clock;

    // Synchronous ROM plus transfer logger.
    always @(posedge clock) begin
        cyc      <= cyc + 1;
        rom_data <= rom[rom_addr];
        if (epoch != seen_epoch) begin
            seen_epoch <= epoch;
            for (int i = 0; i < 4; i++) nack_used[i] <= 0;
        end
        if (reset && sccb_valid && sccb_ready) begin
            if (writes < 64) begin
                wlog[writes] <= {sccb_reg, sccb_val};
                wcyc[writes] <= cyc;
            end
            nack_this         <= (nack_used[rom_addr] < nack_plan[rom_addr]);
            nack_used[rom_addr] <= nack_used[rom_addr] + 1;
            writes            <= writes + 1;
        end
    end

    // SCCB master: ready after ready_stall cycles of valid, done two
    // cycles after the accepted write.
    initial begin : g_master
        int pend;
        int stall;
        int seen;
        pend = 0; stall = 0; seen = 0;
        sccb_ready = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
        forever begin
            @(negedge clock);
            sccb_ready = 1'b0; sccb_done = 1'b0; sccb_nack = 1'b0;
            if (!reset) begin
                pend = 0; stall = 0; seen = writes;
            end else if (writes != seen) begin
                seen = writes; pend = 1;
            end else if (pend > 0) begin
                pend = 0; sccb_done = 1'b1; sccb_nack = nack_this;
            end else if (sccb_valid) begin
                if (stall >= ready_stall) begin
                    sccb_ready = 1'b1; stall = 0;
                end else begin
                    stall++;
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load_rom(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        rom[0] = a; rom[1] = b; rom[2] = c; rom[3] = d;
        for (int i = 0; i < 4; i++) nack_plan[i] = 0;
        ready_stall = 0;
        epoch++;
        @(posedge clock); #1;
        base = writes;
    endtask

    task automatic pulse_start();
        @(negedge clock); start = 1'b1;
        @(negedge clock); start = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int budget);
        int n = 0;
        while (!(done || error) && n < budget) begin
            @(posedge clock); #1; n++;
        end
        check_val(tag, 32'(done || error), 1);
    endtask

    task automatic wait_writes(input string tag, input int target);
        int n = 0;
        while (writes < target && n < 200) begin
            @(posedge clock); #1; n++;
        end
        check_val(tag, 32'(writes >= target), 1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!sccb_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check_val(tag, 32'(sccb_valid), 1);
    endtask

    initial begin : g_watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            rom[i] = 16'hFFFF; nack_plan[i] = 0;
        end
        // ---------------- reset state ----------------
        repeat (3) @(posedge clock); #1;
        check_val("rst valid", 32'(sccb_valid), 0);
        check_val("rst status", {29'd0, busy, done, error}, 0);
        check_val("rst addr", 32'(rom_addr), 0);
        check_val("rst reg/val", {16'd0, sccb_reg, sccb_val}, 0);
        @(negedge clock); reset = 1'b1;
        repeat (2) @(posedge clock); #1;
        check_val("idle busy", 32'(busy), 0);

        // ---------------- soft reset + delay ----------------
        load_rom(16'h1280, 16'h1104, 16'hFFFF, 16'h0000);
        pulse_start();
        wait_end("t1 finish", 200);
        check_val("t1 writes", 32'(writes - base), 2);
        check_val("t1 write0", 32'(wlog[base]), 32'h1280);
        check_val("t1 write1", 32'(wlog[base+1]), 32'h1104);
        check_val("t1 gap", 32'(wcyc[base+1] - wcyc[base]), 9);
        check_val("t1 status", {29'd0, busy, done, error}, 3'b010);

        // ---------------- ready stall ----------------
        load_rom(16'h1155, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        ready_stall = 5;
        pulse_start();
        wait_valid("t2 valid seen");
        for (int k = 0; k < 5; k++) begin
            check_val("t2 valid held", 32'(sccb_valid), 1);
            check_val("t2 reg/val", {16'd0, sccb_reg, sccb_val}, 32'h1155);
            check_val("t2 no early xfer", 32'(writes - base), 0);
            @(posedge clock); #1;
        end
        wait_end("t2 finish", 100);
        check_val("t2 writes", 32'(writes - base), 1);
        check_val("t2 done", 32'(done), 1);

        // ---------------- 3 NACKs then ACK ----------------
        load_rom(16'h1101, 16'h1102, 16'h1103, 16'hFFFF);
        nack_plan[2] = 3;
        pulse_start();
        wait_end("t3 finish", 300);
        check_val("t3 status", {29'd0, busy, done, error}, 3'b010);
        check_val("t3 writes", 32'(writes - base), 6);
        for (int k = 2; k < 6; k++)
            check_val("t3 reissue", 32'(wlog[base+k]), 32'h1103);

        // ---------------- 4 NACKs -> error, then restart ----------------
        load_rom(16'h1101, 16'h1102, 16'h1103, 16'hFFFF);
        nack_plan[2] = 4;
        pulse_start();
        wait_end("t4 finish", 300);
        check_val("t4 status", {29'd0, busy, done, error}, 3'b001);
        check_val("t4 err_index", 32'(err_index), 2);
        check_val("t4 writes", 32'(writes - base), 6);
        repeat (10) @(posedge clock); #1;
        check_val("t4 quiet writes", 32'(writes - base), 6);
        check_val("t4 quiet valid", 32'(sccb_valid), 0);
        check_val("t4 error held", 32'(error), 1);
        pulse_start();
        check_val("t4 restart addr", 32'(rom_addr), 0);
        check_val("t4 restart status", {29'd0, busy, done, error}, 3'b100);
        wait_end("t4 rerun finish", 300);
        check_val("t4 rerun done", 32'(done), 1);
        check_val("t4 rerun writes", 32'(writes - base), 9);

        // ---------------- full ROM, no end marker ----------------
        load_rom(16'h1201, 16'h1202, 16'h1203, 16'h1204);
        pulse_start();
        wait_end("t5 finish", 300);
        check_val("t5 writes", 32'(writes - base), 4);
        check_val("t5 last write", 32'(wlog[base+3]), 32'h1204);
        check_val("t5 addr", 32'(rom_addr), 3);
        repeat (8) @(posedge clock); #1;
        check_val("t5 no wrap addr", 32'(rom_addr), 3);
        check_val("t5 no wrap writes", 32'(writes - base), 4);
        check_val("t5 status", {29'd0, busy, done, error}, 3'b010);

        // ---------------- start ignored while busy ----------------
        load_rom(16'h1101, 16'h1102, 16'hFFFF, 16'hFFFF);
        pulse_start();
        wait_writes("t6 first write", base + 1);
        pulse_start();
        wait_end("t6 finish", 200);
        check_val("t6 writes", 32'(writes - base), 2);
        check_val("t6 write1", 32'(wlog[base+1]), 32'h1102);

        // ---------------- reset during WAIT_DONE ----------------
        load_rom(16'h1101, 16'h1102, 16'hFFFF, 16'hFFFF);
        pulse_start();
        wait_writes("t7 second write", base + 2);
        check_val("t7 pre err_index", 32'(err_index), 2);
        reset = 1'b0;
        #1;
        check_val("t7 valid", 32'(sccb_valid), 0);
        check_val("t7 status", {29'd0, busy, done, error}, 0);
        check_val("t7 addr", 32'(rom_addr), 0);
        check_val("t7 err_index", 32'(err_index), 0);
        check_val("t7 reg/val", {16'd0, sccb_reg, sccb_val}, 0);
        @(negedge clock); #1 reset = 1'b1;
        repeat (10) @(posedge clock); #1;
        check_val("t7 idle busy", 32'(busy), 0);
        check_val("t7 idle writes", 32'(writes - base), 2);

        // ---------------- reset while a request is pending ----------------
        load_rom(16'h1177, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        ready_stall = 8;
        pulse_start();
        wait_valid("t8 valid seen");
        reset = 1'b0;
        #1;
        check_val("t8 valid drop", 32'(sccb_valid), 0);
        @(negedge clock); #1 reset = 1'b1;
        ready_stall = 0;
        repeat (12) @(posedge clock); #1;
        check_val("t8 no xfer", 32'(writes - base), 0);
        check_val("t8 idle", {29'd0, busy, done, error}, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
